// File: rtl/mathip_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mathip_pkg                                                               |
// | Register map, AXI response codes and sequencer state encoding for mathip.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package mathip_pkg;

    localparam logic [31:0] REG_A   = 32'h0000_0000;
    localparam logic [31:0] REG_B   = 32'h0000_0004;
    localparam logic [31:0] REG_OP  = 32'h0000_0008;
    localparam logic [31:0] REG_RES = 32'h0000_000C;

    localparam int N_SLOTS = 3;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_NEXT  = 3'd1,
        S_WR    = 3'd2,
        S_BRESP = 3'd3,
        S_WAIT  = 3'd4,
        S_RADDR = 3'd5,
        S_RDATA = 3'd6,
        S_RSP   = 3'd7
    } seq_state_t;

    // Slot index 0..2 maps onto the word-aligned operand/opcode registers.
    function automatic logic [31:0] slot_offset(input logic [1:0] idx);
        return {28'd0, idx, 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mathip_op_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mathip_op_sequencer_if                                                   |
// | AXI4-Lite bus between the op sequencer (master) and mathip (slave).      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface mathip_op_sequencer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface
`default_nettype wire

// File: rtl/mathip_lite_wr_chan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mathip_lite_wr_chan                                                      |
// | Issues one AW+W pair; each VALID drops on its own handshake.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mathip_lite_wr_chan #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [ADDR_W-1:0] awaddr_o,
    output logic              awvalid_o,
    input  logic              awready_i,
    output logic [DATA_W-1:0] wdata_o,
    output logic              wvalid_o,
    input  logic              wready_i,
    output logic              done_o
);

    logic              awvalid_q;
    logic              wvalid_q;
    logic              busy_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    // Done in the cycle whose edge completes the last outstanding handshake.
    always_comb begin
        done_o = busy_q && !(awvalid_q && !awready_i) && !(wvalid_q && !wready_i);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            busy_q    <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
        end else if (start_i) begin
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            busy_q    <= 1'b1;
            addr_q    <= addr_i;
            data_q    <= data_i;
        end else begin
            if (awvalid_q && awready_i) awvalid_q <= 1'b0;
            if (wvalid_q && wready_i)   wvalid_q  <= 1'b0;
            if (done_o)                 busy_q    <= 1'b0;
        end
    end

    assign awaddr_o  = addr_q;
    assign awvalid_o = awvalid_q;
    assign wdata_o   = data_q;
    assign wvalid_o  = wvalid_q;

endmodule
`default_nettype wire

// File: rtl/mathip_op_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mathip_op_sequencer                                                      |
// | Writes A/B/op to mathip over AXI4-Lite, waits, reads back the result.    |
// | Zero-wait slave, no skips: cmd handshake -> rsp_valid takes              |
// | 3 x (NEXT+WR+BRESP) + NEXT + RESULT_WAIT + RADDR + RDATA                 |
// | = 12 + RESULT_WAIT cycles.                                               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mathip_op_sequencer
    import mathip_pkg::*;
#(
    parameter int              DATA_W         = 32,
    parameter int              ADDR_W         = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
    parameter int              RESULT_WAIT    = 2,
    parameter int              SKIP_REDUNDANT = 1
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [DATA_W-1:0] cmd_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [15:0]       op_count,
    mathip_op_sequencer_if.master m_axi
);

    localparam int WAIT_W = (RESULT_WAIT > 1) ? $clog2(RESULT_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((RESULT_WAIT > 0) ? RESULT_WAIT - 1 : 0);

    seq_state_t        state_q;
    logic [DATA_W-1:0] slot_q  [N_SLOTS];
    logic [DATA_W-1:0] cache_q [N_SLOTS];
    logic [2:0]        done_q;
    logic [2:0]        cache_vld_q;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic              cmd_ready_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_err_q;
    logic [15:0]       op_count_q;
    logic              bready_q;
    logic              arvalid_q;
    logic              rready_q;

    logic [1:0]        w_sel_idx;
    logic              w_all_done;
    logic              w_skip;
    logic              w_wr_start;
    logic              w_wr_done;

    // Lowest slot not yet handled; stays fixed through WR/BRESP because
    // done_q only changes when that slot retires.
    always_comb begin
        w_sel_idx  = 2'd2;
        w_all_done = 1'b1;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (!done_q[i]) begin
                w_sel_idx  = 2'(i);
                w_all_done = 1'b0;
            end
        end
        w_skip     = (SKIP_REDUNDANT != 0) && !w_all_done && cache_vld_q[w_sel_idx] &&
                     (cache_q[w_sel_idx] == slot_q[w_sel_idx]);
        w_wr_start = (state_q == S_NEXT) && !w_all_done && !w_skip;
    end

    mathip_lite_wr_chan #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_wr_chan (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .start_i   (w_wr_start),
        .addr_i    (ADDR_W'(BASE_ADDR + slot_offset(w_sel_idx))),
        .data_i    (slot_q[w_sel_idx]),
        .awaddr_o  (m_axi.awaddr),
        .awvalid_o (m_axi.awvalid),
        .awready_i (m_axi.awready),
        .wdata_o   (m_axi.wdata),
        .wvalid_o  (m_axi.wvalid),
        .wready_i  (m_axi.wready),
        .done_o    (w_wr_done)
    );

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= S_IDLE;
            slot_q      <= '{default: '0};
            cache_q     <= '{default: '0};
            done_q      <= '0;
            cache_vld_q <= '0;
            wait_cnt_q  <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            op_count_q  <= '0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        slot_q[0]   <= cmd_a;
                        slot_q[1]   <= cmd_b;
                        slot_q[2]   <= cmd_op;
                        done_q      <= '0;
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b0;
                        cmd_ready_q <= 1'b0;
                        state_q     <= S_NEXT;
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                S_NEXT: begin
                    if (w_all_done) begin
                        if (RESULT_WAIT == 0) begin
                            arvalid_q <= 1'b1;
                            state_q   <= S_RADDR;
                        end else begin
                            wait_cnt_q <= '0;
                            state_q    <= S_WAIT;
                        end
                    end else if (w_skip) begin
                        done_q[w_sel_idx] <= 1'b1;
                    end else begin
                        state_q <= S_WR;
                    end
                end
                S_WR: begin
                    if (w_wr_done) begin
                        bready_q <= 1'b1;
                        state_q  <= S_BRESP;
                    end
                end
                S_BRESP: begin
                    if (m_axi.bvalid) begin
                        bready_q <= 1'b0;
                        if (axi_resp_t'(m_axi.bresp) == RESP_OKAY) begin
                            cache_q[w_sel_idx]     <= slot_q[w_sel_idx];
                            cache_vld_q[w_sel_idx] <= 1'b1;
                            done_q[w_sel_idx]      <= 1'b1;
                            state_q                <= S_NEXT;
                        end else begin
                            // A failed write leaves mathip contents unknown.
                            cache_vld_q <= '0;
                            rsp_err_q   <= 1'b1;
                            rsp_data_q  <= '0;
                            rsp_valid_q <= 1'b1;
                            state_q     <= S_RSP;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt_q == WAIT_LAST) begin
                        arvalid_q <= 1'b1;
                        state_q   <= S_RADDR;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                S_RADDR: begin
                    if (m_axi.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_RDATA;
                    end
                end
                S_RDATA: begin
                    if (m_axi.rvalid) begin
                        rready_q <= 1'b0;
                        if (axi_resp_t'(m_axi.rresp) == RESP_OKAY) begin
                            rsp_data_q <= m_axi.rdata;
                        end else begin
                            rsp_data_q <= '0;
                            rsp_err_q  <= 1'b1;
                        end
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RSP;
                    end
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        op_count_q  <= op_count_q + 16'd1;
                        cmd_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_err       = rsp_err_q;
    assign op_count      = op_count_q;

    assign m_axi.awprot  = 3'b000;
    assign m_axi.wstrb   = '1;
    assign m_axi.bready  = bready_q;
    assign m_axi.araddr  = ADDR_W'(BASE_ADDR + REG_RES);
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready_q;

endmodule
`default_nettype wire
